// File: rtl/mmio_initiator.sv
// Host-side MMIO master: one outstanding request to the AFU, odd/even parity, ack timeout.
// Define MMIO_INITIATOR_STATS_EN to add saturating read/write/error/timeout/stray-ack counters.

package mmio_initiator_pkg;
  typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [0:23] address;
    logic        address_parity;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic        ack;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceOutput;
endpackage

module mmio_initiator
  import mmio_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit ODD_PARITY     = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_read,
  input  logic               cmd_cfg,
  input  logic               cmd_doubleword,
  input  logic [0:23]        cmd_address,
  input  logic [0:63]        cmd_data,
  output MMIOInterfaceInput  mmio_req,
  input  MMIOInterfaceOutput mmio_rsp,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [0:63]        rsp_data,
  output logic               rsp_parity_error,
  output logic               rsp_timeout
`ifdef MMIO_INITIATOR_STATS_EN
  ,
  output logic [0:31]        stat_reads,
  output logic [0:31]        stat_writes,
  output logic [0:31]        stat_parity_errors,
  output logic [0:31]        stat_timeouts,
  output logic [0:31]        stat_stray_acks
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  MMIOInterfaceInput r_req;
  logic [CW-1:0]     r_count;
  logic              r_rsp_valid;
  logic [0:63]       r_rsp_data;
  logic              r_rsp_perr;
  logic              r_rsp_timeout;

  logic              w_accept;
  logic              w_ack;
  logic              w_expire;
  logic              w_ack_perr;
  logic [0:63]       w_wdata;
  logic [0:63]       w_rdata;

  function automatic logic f_parity(input logic [0:63] x);
    return (^x) ^ ODD_PARITY;
  endfunction

  assign w_accept   = (r_state == IDLE) && r_cmd_ready && cmd_valid;
  assign w_ack      = (r_state == WAIT_ACK) && mmio_rsp.ack;
  assign w_expire   = (r_state == WAIT_ACK) && !mmio_rsp.ack && (r_count == LAST_COUNT);
  assign w_ack_perr = r_req.read && (f_parity(mmio_rsp.data) != mmio_rsp.data_parity);

  // Word writes replicate the low half so the AFU sees the word on either lane.
  assign w_wdata = cmd_read       ? 64'h0 :
                   cmd_doubleword ? cmd_data :
                                    {cmd_data[32:63], cmd_data[32:63]};

  assign w_rdata = !r_req.read      ? 64'h0 :
                   r_req.doubleword ? mmio_rsp.data :
                   {32'h0, r_req.address[23] ? mmio_rsp.data[32:63] : mmio_rsp.data[0:31]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state              <= IDLE;
      r_cmd_ready          <= 1'b0;
      r_req                <= '0;
      r_req.address_parity <= ODD_PARITY;
      r_req.data_parity    <= ODD_PARITY;
      r_count              <= '0;
      r_rsp_valid          <= 1'b0;
      r_rsp_data           <= '0;
      r_rsp_perr           <= 1'b0;
      r_rsp_timeout        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready          <= 1'b0;
            r_req.valid          <= 1'b1;
            r_req.cfg            <= cmd_cfg;
            r_req.read           <= cmd_read;
            r_req.doubleword     <= cmd_doubleword;
            r_req.address        <= cmd_address;
            r_req.address_parity <= f_parity({40'h0, cmd_address});
            r_req.data           <= w_wdata;
            r_req.data_parity    <= f_parity(w_wdata);
            r_state              <= ISSUE;
          end
        end
        ISSUE: begin
          r_req.valid <= 1'b0;
          r_count     <= '0;
          r_state     <= WAIT_ACK;
        end
        // An ack on the final count cycle still wins over the timeout.
        WAIT_ACK: begin
          if (w_ack) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rdata;
            r_rsp_perr  <= w_ack_perr;
            r_state     <= RESP;
          end else if (w_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_perr    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign mmio_req         = r_req;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign rsp_parity_error = r_rsp_perr;
  assign rsp_timeout      = r_rsp_timeout;

`ifdef MMIO_INITIATOR_STATS_EN
  logic [0:31] r_stat_reads;
  logic [0:31] r_stat_writes;
  logic [0:31] r_stat_perr;
  logic [0:31] r_stat_timeouts;
  logic [0:31] r_stat_stray;

  function automatic logic [0:31] f_sat_inc(input logic [0:31] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Any ack outside WAIT_ACK is discarded by the FSM and counted here as stray.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_reads    <= '0;
      r_stat_writes   <= '0;
      r_stat_perr     <= '0;
      r_stat_timeouts <= '0;
      r_stat_stray    <= '0;
    end else begin
      if (r_state == ISSUE && r_req.read)      r_stat_reads    <= f_sat_inc(r_stat_reads);
      if (r_state == ISSUE && !r_req.read)     r_stat_writes   <= f_sat_inc(r_stat_writes);
      if (w_ack && w_ack_perr)                 r_stat_perr     <= f_sat_inc(r_stat_perr);
      if (w_expire)                            r_stat_timeouts <= f_sat_inc(r_stat_timeouts);
      if (mmio_rsp.ack && r_state != WAIT_ACK) r_stat_stray    <= f_sat_inc(r_stat_stray);
    end
  end

  assign stat_reads         = r_stat_reads;
  assign stat_writes        = r_stat_writes;
  assign stat_parity_errors = r_stat_perr;
  assign stat_timeouts      = r_stat_timeouts;
  assign stat_stray_acks    = r_stat_stray;
`endif

endmodule

// File: tb/tb_mmio_initiator.sv
// Self-checking bench for mmio_initiator: directed cases plus randomized transactions against
// a behavioural model; counter checks compile in when MMIO_INITIATOR_STATS_EN is defined.

module tb_mmio_initiator;
  import mmio_initiator_pkg::*;

  localparam int TO  = 8;
  localparam bit ODD = 1'b1;

  logic               clock = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_read;
  logic               cmd_cfg;
  logic               cmd_doubleword;
  logic [0:23]        cmd_address;
  logic [0:63]        cmd_data;
  MMIOInterfaceInput  mmio_req;
  MMIOInterfaceOutput mmio_rsp;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [0:63]        rsp_data;
  logic               rsp_parity_error;
  logic               rsp_timeout;
`ifdef MMIO_INITIATOR_STATS_EN
  logic [0:31] stat_reads, stat_writes, stat_parity_errors, stat_timeouts, stat_stray_acks;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  int expReads, expWrites, expPerr, expTimeouts, expStray;

  mmio_initiator #(.TIMEOUT_CYCLES(TO), .ODD_PARITY(ODD)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_cfg(cmd_cfg),
    .cmd_doubleword(cmd_doubleword), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .mmio_req(mmio_req), .mmio_rsp(mmio_rsp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_parity_error(rsp_parity_error), .rsp_timeout(rsp_timeout)
`ifdef MMIO_INITIATOR_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_parity_errors(stat_parity_errors),
    .stat_timeouts(stat_timeouts), .stat_stray_acks(stat_stray_acks)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic refParity(input logic [63:0] v);
    int ones;
    ones = $countones(v);
    return ODD ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic MMIOInterfaceInput refRequest(input bit rd, input bit cfg, input bit dw,
                                                   input logic [23:0] addr, input logic [63:0] wdata);
    MMIOInterfaceInput r;
    logic [63:0] lo;
    logic [63:0] d;
    lo = wdata & 64'hFFFF_FFFF;
    d  = rd ? 64'h0 : (dw ? wdata : ((lo << 32) | lo));
    r.valid = 1'b1; r.cfg = cfg; r.read = rd; r.doubleword = dw; r.address = addr;
    r.address_parity = refParity({40'h0, addr});
    r.data = d; r.data_parity = refParity(d);
    return r;
  endfunction

  // Returns {data, parity_error, timeout}; an ack at wait cycle >= TO never lands.
  function automatic logic [65:0] refResponse(input bit rd, input bit dw, input logic [23:0] addr,
                                              input int lat, input logic [63:0] adata, input bit apar);
    logic [63:0] d;
    if (lat >= TO) return {64'h0, 1'b0, 1'b1};
    if (!rd) return 66'h0;
    d = dw ? adata : ((addr % 2 == 1) ? (adata & 64'hFFFF_FFFF) : (adata >> 32));
    return {d, refParity(adata) != apar, 1'b0};
  endfunction

  task automatic clearStatsModel();
    expReads = 0; expWrites = 0; expPerr = 0; expTimeouts = 0; expStray = 0;
  endtask

  task automatic runTxn(input bit rd, input bit cfg, input bit dw, input logic [23:0] addr,
                        input logic [63:0] wdata, input int lat, input logic [63:0] adata,
                        input bit apar, input int hold, input int strayAt,
                        output MMIOInterfaceInput oReq, output int oPulses, output int oCycles,
                        output logic [65:0] oRsp, output bit oStable, output bit oDone);
    int waitCount;
    bit seen;
    logic [65:0] expRsp;
    oReq = '0; oPulses = 0; oCycles = -1; oRsp = '0; oStable = 1'b1; oDone = 1'b0;
    waitCount = 0; seen = 1'b0;
    while (cmd_ready !== 1'b1 && waitCount < 50) begin
      @(negedge clock);
      waitCount++;
    end
    cmd_valid = 1'b1; cmd_read = rd; cmd_cfg = cfg; cmd_doubleword = dw;
    cmd_address = addr; cmd_data = wdata;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_read = 1'($urandom); cmd_cfg = 1'($urandom);
    cmd_doubleword = 1'($urandom); cmd_address = 24'($urandom); cmd_data = {$urandom, $urandom};
    oReq = mmio_req;
    if (mmio_req.valid) oPulses++;
    for (int n = 0; n < TO + 20 && !seen; n++) begin
      @(negedge clock);
      mmio_rsp.ack = 1'b0;
      mmio_rsp.data = {$urandom, $urandom};
      mmio_rsp.data_parity = 1'($urandom);
      if (mmio_req.valid) oPulses++;
      if (rsp_valid) begin
        seen = 1'b1;
        oCycles = n;
      end else if (n == lat) begin
        mmio_rsp.ack = 1'b1; mmio_rsp.data = adata; mmio_rsp.data_parity = apar;
      end
    end
    if (!seen) return;
    oDone = 1'b1;
    oRsp = {rsp_data, rsp_parity_error, rsp_timeout};
    for (int h = 0; h < hold; h++) begin
      if (h == strayAt) begin
        mmio_rsp.ack = 1'b1;
        mmio_rsp.data = {$urandom, $urandom};
      end
      @(negedge clock);
      mmio_rsp.ack = 1'b0;
      if (rsp_valid !== 1'b1 || {rsp_data, rsp_parity_error, rsp_timeout} !== oRsp ||
          cmd_ready !== 1'b0 || mmio_req.valid !== 1'b0) oStable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) oStable = 1'b0;
    expRsp = refResponse(rd, dw, addr, lat, adata, apar);
    if (rd) expReads++; else expWrites++;
    if (expRsp[0]) expTimeouts++;
    if (expRsp[1]) expPerr++;
    if (strayAt >= 0 && strayAt < hold) expStray++;
  endtask

  task automatic test_reset();
    MMIOInterfaceInput rr;
    rr = '0; rr.address_parity = ODD; rr.data_parity = ODD;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    clearStatsModel();
    nCompared++;
    if (cmd_ready !== 1'b0) begin nMismatched++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    nCompared++;
    if (mmio_req !== rr) begin nMismatched++; $display("FAIL reset_mmio_req: got %h expected %h", mmio_req, rr); end
    nCompared++;
    if ({rsp_valid, rsp_data, rsp_parity_error, rsp_timeout} !== 67'h0) begin
      nMismatched++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_data, rsp_parity_error, rsp_timeout});
    end
`ifdef MMIO_INITIATOR_STATS_EN
    nCompared++;
    if ({stat_reads, stat_writes, stat_parity_errors, stat_timeouts, stat_stray_acks} !== 160'h0) begin
      nMismatched++; $display("FAIL reset_stats: counters not zero");
    end
`endif
    reset = 1'b0;
    @(negedge clock);
    nCompared++;
    if (cmd_ready !== 1'b1) begin nMismatched++; $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_directed();
    MMIOInterfaceInput oReq;
    int pulses, cycles;
    logic [65:0] rsp;
    bit stable, done;
    logic [63:0] ad;

    ad = 64'h0000_0001_0001_8010;
    runTxn(1, 1, 1, 24'h000000, 64'h0, 3, ad, refParity(ad), 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (pulses !== 1) begin nMismatched++; $display("FAIL cfg_read_pulses: got %0d expected 1", pulses); end
    nCompared++;
    if (oReq.address_parity !== 1'b1) begin nMismatched++; $display("FAIL cfg_read_addr_parity: got %b expected 1", oReq.address_parity); end
    nCompared++;
    if (oReq !== refRequest(1, 1, 1, 24'h0, 64'h0)) begin
      nMismatched++; $display("FAIL cfg_read_req: got %h expected %h", oReq, refRequest(1, 1, 1, 24'h0, 64'h0));
    end
    nCompared++;
    if (rsp !== {64'h0000_0001_0001_8010, 2'b00}) begin nMismatched++; $display("FAIL cfg_read_rsp: got %h expected %h", rsp, {ad, 2'b00}); end
    nCompared++;
    if (cycles !== 4) begin nMismatched++; $display("FAIL cfg_read_latency: got %0d expected 4", cycles); end

    runTxn(0, 0, 0, 24'h000012, 64'h12345678_DEADBEEF, 1, 64'h0, 1'b0, 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (oReq.data !== 64'hDEADBEEF_DEADBEEF) begin nMismatched++; $display("FAIL write_word_data: got %h expected deadbeefdeadbeef", oReq.data); end
    nCompared++;
    if ({oReq.read, oReq.cfg, oReq.valid} !== 3'b001) begin nMismatched++; $display("FAIL write_word_flags: got %b expected 001", {oReq.read, oReq.cfg, oReq.valid}); end
    nCompared++;
    if (oReq.data_parity !== refParity(64'hDEADBEEF_DEADBEEF)) begin nMismatched++; $display("FAIL write_word_parity: got %b", oReq.data_parity); end
    nCompared++;
    if (rsp !== 66'h0 || !done) begin nMismatched++; $display("FAIL write_word_rsp: got %h expected 0", rsp); end

    ad = 64'h11112222_33334444;
    runTxn(1, 0, 0, 24'h000003, 64'h0, 2, ad, refParity(ad), 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (rsp !== {64'h00000000_33334444, 2'b00}) begin nMismatched++; $display("FAIL read_word_odd_rsp: got %h expected %h", rsp, {64'h33334444, 2'b00}); end

    runTxn(1, 0, 0, 24'h000004, 64'h0, 2, ad, refParity(ad), 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (rsp !== {64'h00000000_11112222, 2'b00}) begin nMismatched++; $display("FAIL read_word_even_rsp: got %h expected %h", rsp, {64'h11112222, 2'b00}); end

    ad = 64'hA5A5_0F0F_1234_8001;
    runTxn(1, 0, 1, 24'h000100, 64'h0, 1, ad, !refParity(ad), 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (rsp !== {ad, 2'b10}) begin nMismatched++; $display("FAIL read_bad_parity_rsp: got %h expected %h", rsp, {ad, 2'b10}); end
  endtask

  task automatic test_timeout_and_boundary();
    MMIOInterfaceInput oReq;
    int pulses, cycles;
    logic [65:0] rsp;
    bit stable, done;
    logic [63:0] ad;

    runTxn(1, 0, 1, 24'h00ABCD, 64'h0, 1000, 64'h0, 1'b0, 10, 2, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (cycles !== TO) begin nMismatched++; $display("FAIL timeout_latency: got %0d expected %0d", cycles, TO); end
    nCompared++;
    if (rsp !== 66'h1) begin nMismatched++; $display("FAIL timeout_rsp: got %h expected 1", rsp); end
    nCompared++;
    if (stable !== 1'b1) begin nMismatched++; $display("FAIL timeout_stray_hold: got %b expected 1", stable); end

    ad = 64'hCAFE_F00D_0BAD_BEEF;
    runTxn(1, 1, 1, 24'h000040, 64'h0, TO - 1, ad, refParity(ad), 0, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (rsp !== {ad, 2'b00}) begin nMismatched++; $display("FAIL last_cycle_ack_rsp: got %h expected %h", rsp, {ad, 2'b00}); end
    nCompared++;
    if (cycles !== TO) begin nMismatched++; $display("FAIL last_cycle_ack_latency: got %0d expected %0d", cycles, TO); end

    runTxn(0, 0, 1, 24'h000008, 64'h0102_0304_0506_0708, 0, 64'h0, 1'b0, 10, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (cycles !== 1) begin nMismatched++; $display("FAIL zero_latency_ack: got %0d expected 1", cycles); end
    nCompared++;
    if (stable !== 1'b1) begin nMismatched++; $display("FAIL backpressure_hold: got %b expected 1", stable); end
  endtask

  task automatic test_reset_mid();
    MMIOInterfaceInput oReq;
    int pulses, cycles, highCount;
    logic [65:0] rsp;
    bit stable, done;
    logic [63:0] ad;

    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_cfg = 1'b0; cmd_doubleword = 1'b1;
    cmd_address = 24'h000020; cmd_data = '0;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    clearStatsModel();
    nCompared++;
    if ({rsp_valid, mmio_req.valid, cmd_ready} !== 3'b000) begin
      nMismatched++; $display("FAIL mid_reset_state: got %b expected 000", {rsp_valid, mmio_req.valid, cmd_ready});
    end
    reset = 1'b0;
    @(negedge clock);
    mmio_rsp.ack = 1'b1; mmio_rsp.data = 64'hFFFF_0000_FFFF_0000;
    expStray++;
    highCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mmio_rsp.ack = 1'b0;
      if (rsp_valid !== 1'b0) highCount++;
    end
    nCompared++;
    if (highCount !== 0) begin nMismatched++; $display("FAIL late_ack_ignored: got %0d cycles of rsp_valid expected 0", highCount); end

    ad = 64'h0F1E_2D3C_4B5A_6978;
    runTxn(1, 0, 1, 24'h000021, 64'h0, 2, ad, refParity(ad), 1, -1, oReq, pulses, cycles, rsp, stable, done);
    nCompared++;
    if (rsp !== {ad, 2'b00} || !done) begin nMismatched++; $display("FAIL after_reset_txn: got %h expected %h", rsp, {ad, 2'b00}); end
  endtask

  task automatic test_random();
    MMIOInterfaceInput oReq;
    int pulses, cycles, lat, hold, strayAt, expCycles;
    logic [65:0] rsp;
    bit stable, done, rd, cfg, dw, apar;
    logic [23:0] addr;
    logic [63:0] wdata, adata;

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom); cfg = 1'($urandom); dw = 1'($urandom);
      addr = 24'($urandom); wdata = {$urandom, $urandom}; adata = {$urandom, $urandom};
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 1, TO + 3)) : int'($urandom_range(0, 5));
      apar = ($urandom_range(0, 4) == 0) ? !refParity(adata) : refParity(adata);
      hold = int'($urandom_range(0, 3));
      strayAt = ($urandom_range(0, 3) == 0 && hold > 0) ? int'($urandom_range(0, hold - 1)) : -1;
      expCycles = (lat < TO) ? lat + 1 : TO;
      runTxn(rd, cfg, dw, addr, wdata, lat, adata, apar, hold, strayAt, oReq, pulses, cycles, rsp, stable, done);
      nCompared++;
      if (oReq !== refRequest(rd, cfg, dw, addr, wdata)) begin
        nMismatched++; $display("FAIL rand%0d_req: got %h expected %h", i, oReq, refRequest(rd, cfg, dw, addr, wdata));
      end
      nCompared++;
      if (pulses !== 1) begin nMismatched++; $display("FAIL rand%0d_pulses: got %0d expected 1", i, pulses); end
      nCompared++;
      if (cycles !== expCycles) begin nMismatched++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, cycles, expCycles); end
      nCompared++;
      if (rsp !== refResponse(rd, dw, addr, lat, adata, apar)) begin
        nMismatched++; $display("FAIL rand%0d_rsp: got %h expected %h", i, rsp, refResponse(rd, dw, addr, lat, adata, apar));
      end
      nCompared++;
      if (stable !== 1'b1 || done !== 1'b1) begin nMismatched++; $display("FAIL rand%0d_handshake: got %b%b expected 11", i, stable, done); end
    end
  endtask

`ifdef MMIO_INITIATOR_STATS_EN
  task automatic test_stats();
    nCompared++;
    if (stat_reads !== 32'(expReads)) begin nMismatched++; $display("FAIL stat_reads: got %0d expected %0d", stat_reads, expReads); end
    nCompared++;
    if (stat_writes !== 32'(expWrites)) begin nMismatched++; $display("FAIL stat_writes: got %0d expected %0d", stat_writes, expWrites); end
    nCompared++;
    if (stat_parity_errors !== 32'(expPerr)) begin nMismatched++; $display("FAIL stat_parity_errors: got %0d expected %0d", stat_parity_errors, expPerr); end
    nCompared++;
    if (stat_timeouts !== 32'(expTimeouts)) begin nMismatched++; $display("FAIL stat_timeouts: got %0d expected %0d", stat_timeouts, expTimeouts); end
    nCompared++;
    if (stat_stray_acks !== 32'(expStray)) begin nMismatched++; $display("FAIL stat_stray_acks: got %0d expected %0d", stat_stray_acks, expStray); end
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_cfg = 1'b0; cmd_doubleword = 1'b0;
    cmd_address = '0; cmd_data = '0; mmio_rsp = '0; rsp_ready = 1'b0;
    clearStatsModel();
    $display("[TB] mmio_initiator bench start");
    test_reset();
    test_directed();
    test_timeout_and_boundary();
`ifdef MMIO_INITIATOR_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    test_random();
`ifdef MMIO_INITIATOR_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
